fifo_read_arbiter: RTL and testbench

FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

---
 rtl/fifo_read_arbiter.sv | 76 +++++++
 tb/tb_fifo_read_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin reader that drains NUM_FIFOS FIFO read ports one word at a time
// into a single registered valid/ready output stream.
module fifo_read_arbiter #(
  parameter int NUM_FIFOS = 4,
  parameter int DATA_WIDTH = 36,
  localparam int SW = $clog2(NUM_FIFOS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable_i,
  input  logic [NUM_FIFOS-1:0]            fifo_empty_i,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data_i,
  output logic [NUM_FIFOS-1:0]            fifo_rden_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [SW-1:0]                   src_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [15:0]                     xfer_count_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
  localparam logic [SW:0] NF = (SW+1)'(NUM_FIFOS);
  state_t r_state, w_next;
  logic [SW-1:0] r_rr, r_win, w_win, w_off;
  logic [NUM_FIFOS-1:0] w_rot;
  logic [SW:0] w_sum, w_inc;
  logic w_any, w_grant;
  // rotate the non-empty mask so bit 0 lines up with rr_ptr; lowest set bit is the winner's offset
  assign w_rot = NUM_FIFOS'({~fifo_empty_i, ~fifo_empty_i} >> r_rr);
  always_comb begin
    w_off = '0;
    for (int i = NUM_FIFOS-1; i >= 0; i--) if (w_rot[i]) w_off = SW'(i);
  end
  assign w_any = |w_rot;
  assign w_sum = {1'b0, r_rr} + {1'b0, w_off};
  assign w_win = w_sum >= NF ? SW'(w_sum - NF) : w_sum[SW-1:0];
  assign w_inc = {1'b0, w_win} + 1'b1;
  assign w_grant = enable_i && w_any && (r_state == IDLE || (r_state == HOLD && ready_i));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_grant ? ISSUE : IDLE;
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = HOLD;
      HOLD:    w_next = w_grant ? ISSUE : (ready_i ? IDLE : HOLD);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_rr         <= '0;
      r_win        <= '0;
      fifo_rden_o  <= '0;
      data_o       <= '0;
      src_o        <= '0;
      valid_o      <= 1'b0;
      xfer_count_o <= '0;
    end else begin
      r_state     <= w_next;
      fifo_rden_o <= w_grant ? NUM_FIFOS'(1) << w_win : '0;
      if (w_grant) begin
        r_win <= w_win;
        r_rr  <= w_inc == NF ? '0 : w_inc[SW-1:0];
      end
      if (r_state == CAPTURE) begin
        data_o  <= fifo_data_i[r_win*DATA_WIDTH +: DATA_WIDTH];
        src_o   <= r_win;
        valid_o <= 1'b1;
      end
      if (r_state == HOLD && ready_i) begin
        valid_o      <= 1'b0;
        xfer_count_o <= xfer_count_o + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: vector table, directed corner sequences and a randomized drain
// checked against a round-robin transaction model built on per-FIFO word queues.
module tb_fifo_read_arbiter;
  localparam int N = 4, DW = 36;
  typedef struct {int idx; logic [DW-1:0] word; logic [N-1:0] exp_rden; logic [1:0] exp_src;} vec_t;
  logic clk = 1'b0, reset = 1'b0, enable_i = 1'b0, ready_i = 1'b0;
  logic [N-1:0] fifo_empty_i = '1;
  logic [N*DW-1:0] fifo_data_i = '0;
  logic [N-1:0] fifo_rden_o;
  logic [DW-1:0] data_o;
  logic [1:0] src_o;
  logic valid_o;
  logic [15:0] xfer_count_o;
  int errors = 0, checks = 0, underflow = 0, bad_oh = 0, bad_hold = 0, rden_pulses = 0;
  logic [DW-1:0] q [N][$];
  logic [DW-1:0] mq [N][$];
  int m_rr = 0;
  logic sb_on = 1'b0, p_hold = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic [1:0] p_src = '0;

  fifo_read_arbiter #(.NUM_FIFOS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i), .fifo_rden_o(fifo_rden_o), .data_o(data_o), .src_o(src_o),
    .valid_o(valid_o), .ready_i(ready_i), .xfer_count_o(xfer_count_o));

  always #5 clk = ~clk;

  // FIFO models: registered read data and a registered empty flag
  always @(posedge clk) begin
    for (int n = 0; n < N; n++)
      if (fifo_rden_o[n]) begin
        if (q[n].size() == 0) underflow++;
        else fifo_data_i[n*DW +: DW] <= q[n].pop_front();
      end
    for (int n = 0; n < N; n++) fifo_empty_i[n] <= (q[n].size() == 0);
  end

  // protocol monitor and round-robin scoreboard
  always @(posedge clk) begin
    int w;
    if ($countones(fifo_rden_o) > 1) bad_oh++;
    if (fifo_rden_o != '0) rden_pulses++;
    if (reset && p_hold && !(valid_o && data_o == p_data && src_o == p_src)) bad_hold++;
    p_hold = reset && valid_o && !ready_i;
    p_data = data_o;
    p_src = src_o;
    if (sb_on && reset && valid_o && ready_i) begin
      w = -1;
      for (int i = 0; i < N; i++) if (w < 0 && mq[(m_rr+i)%N].size() != 0) w = (m_rr+i)%N;
      checks++;
      if (w < 0) begin
        errors++;
        $display("FAIL sb_extra: got src=%0d data=%0h expected no transfer", src_o, data_o);
      end else begin
        if (src_o !== 2'(w) || data_o !== mq[w][0]) begin
          errors++;
          $display("FAIL sb_xfer: got src=%0d data=%0h expected src=%0d data=%0h", src_o, data_o, w, mq[w][0]);
        end
        void'(mq[w].pop_front());
        m_rr = (w + 1) % N;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!valid_o && n < 40);
    chk({name, "_timeout"}, 64'(valid_o), 64'd1);
  endtask

  function automatic int remaining();
    int s = 0;
    for (int n = 0; n < N; n++) s += mq[n].size();
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
    for (int n = 0; n < N; n++) begin q[n].delete(); mq[n].delete(); end
    @(negedge clk); @(negedge clk);
    chk("rst_rden", 64'(fifo_rden_o), 64'd0);
    chk("rst_valid_data_src", {27'd0, valid_o, data_o}, 64'd0);
    chk("rst_src_cnt", {src_o, xfer_count_o}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vec_t vt[4];
    logic [DW-1:0] ww;
    logic [63:0] rw;
    int p0, total, cyc;
    vt[0] = '{2, 36'h123456789, 4'b0100, 2'd2};
    vt[1] = '{0, 36'hFFFFFFFFF, 4'b0001, 2'd0};
    vt[2] = '{3, 36'h0A5A5A5A5, 4'b1000, 2'd3};
    vt[3] = '{1, 36'h000000001, 4'b0010, 2'd1};
    for (int v = 0; v < 4; v++) begin
      do_reset();
      enable_i = 1'b1; ready_i = 1'b1;
      q[vt[v].idx].push_back(vt[v].word);
      @(negedge clk); chk("vec_rden_pre", 64'(fifo_rden_o), 64'd0);
      @(negedge clk); chk("vec_rden", 64'(fifo_rden_o), 64'(vt[v].exp_rden));
      @(negedge clk); chk("vec_rden_off", {63'd0, valid_o} | 64'(fifo_rden_o), 64'd0);
      @(negedge clk);
      chk("vec_valid", 64'(valid_o), 64'd1);
      chk("vec_data", 64'(data_o), 64'(vt[v].word));
      chk("vec_src", 64'(src_o), 64'(vt[v].exp_src));
      chk("vec_cnt0", 64'(xfer_count_o), 64'd0);
      @(negedge clk);
      chk("vec_drop", 64'(valid_o), 64'd0);
      chk("vec_cnt1", 64'(xfer_count_o), 64'd1);
      chk("vec_retain", 64'(data_o), 64'(vt[v].word));
    end
    // four FIFOs x three words, continuous ready
    do_reset();
    enable_i = 1'b1; ready_i = 1'b1;
    for (int n = 0; n < N; n++) for (int k = 0; k < 3; k++) q[n].push_back(36'hA00 + DW'(n*16 + k));
    for (int i = 0; i < 12; i++) begin
      wait_valid("rr12");
      ww = 36'hA00 + DW'((i%4)*16 + i/4);
      chk("rr12_src", 64'(src_o), 64'(i%4));
      chk("rr12_data", 64'(data_o), 64'(ww));
    end
    repeat (4) @(negedge clk);
    chk("rr12_cnt", 64'(xfer_count_o), 64'd12);
    chk("rr12_empty", 64'(fifo_empty_i), 64'hF);
    // backpressure
    do_reset();
    enable_i = 1'b1;
    q[1].push_back(36'h111111111); q[1].push_back(36'h222222222);
    wait_valid("bp");
    chk("bp_data", 64'(data_o), 64'h111111111);
    p0 = rden_pulses;
    repeat (10) @(negedge clk);
    chk("bp_hold", {26'd0, valid_o, src_o, data_o}, {26'd0, 1'b1, 2'd1, 36'h111111111});
    chk("bp_no_rden", 64'(rden_pulses - p0), 64'd0);
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_accept", {47'd0, valid_o, xfer_count_o}, 64'd1);
    ready_i = 1'b0;
    wait_valid("bp2");
    chk("bp2_data", 64'(data_o), 64'h222222222);
    repeat (3) @(negedge clk);
    chk("bp2_cnt", 64'(xfer_count_o), 64'd1);
    // pointer wrap: grant to 2, then only 0 and 3 pending
    do_reset();
    enable_i = 1'b1;
    q[2].push_back(36'h200000002);
    wait_valid("wrap");
    chk("wrap_src2", 64'(src_o), 64'd2);
    q[0].push_back(36'h000000B0B); q[3].push_back(36'h000000C0C);
    repeat (2) @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    wait_valid("wrap3");
    chk("wrap_src3", {src_o, data_o}, {26'd0, 2'd3, 36'h000000C0C});
    wait_valid("wrap0");
    chk("wrap_src0", {src_o, data_o}, {26'd0, 2'd0, 36'h000000B0B});
    // enable dropped during CAPTURE
    do_reset();
    enable_i = 1'b1; ready_i = 1'b1;
    q[1].push_back(36'h0000000D1); q[1].push_back(36'h0000000E1);
    @(negedge clk);
    @(negedge clk); chk("en_rden", 64'(fifo_rden_o), 64'b0010);
    @(negedge clk); enable_i = 1'b0;
    @(negedge clk); chk("en_deliver", {27'd0, valid_o, data_o}, {27'd0, 1'b1, 36'h0000000D1});
    @(negedge clk); chk("en_accept", {47'd0, valid_o, xfer_count_o}, 64'd1);
    p0 = rden_pulses;
    repeat (5) @(negedge clk);
    chk("en_blocked", 64'(rden_pulses - p0), 64'd0);
    chk("en_idle_valid", 64'(valid_o), 64'd0);
    enable_i = 1'b1;
    wait_valid("en_resume");
    chk("en_resume_data", 64'(data_o), 64'h0000000E1);
    // reset pulsed during HOLD
    do_reset();
    enable_i = 1'b1;
    q[1].push_back(36'h000000F01); q[1].push_back(36'h000000F02); q[3].push_back(36'h000000F03);
    wait_valid("rh1");
    chk("rh1_src", 64'(src_o), 64'd1);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    wait_valid("rh2");
    chk("rh2", {src_o, xfer_count_o, 46'd0}, {2'd3, 16'd1, 46'd0});
    q[3].push_back(36'h000000F04);
    #2 reset = 1'b0;
    #1;
    chk("rh_async_valid_rden", {59'd0, valid_o, fifo_rden_o}, 64'd0);
    chk("rh_async_cnt_data", {xfer_count_o, data_o}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1; ready_i = 1'b1;
    wait_valid("rh_after");
    chk("rh_after", {src_o, data_o}, {26'd0, 2'd1, 36'h000000F02});
    // randomized drain against the round-robin model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      m_rr = 0; total = 0;
      for (int n = 0; n < N; n++)
        for (int k = $urandom_range(0, 5); k > 0; k--) begin
          rw = {$urandom(), $urandom()};
          q[n].push_back(rw[DW-1:0]); mq[n].push_back(rw[DW-1:0]);
          total++;
        end
      sb_on = 1'b1;
      cyc = 0;
      while (remaining() > 0 && cyc < 3000) begin
        @(negedge clk);
        ready_i = $urandom_range(0, 2) != 0;
        enable_i = $urandom_range(0, 3) != 0;
        cyc++;
      end
      repeat (3) @(negedge clk);
      sb_on = 1'b0;
      chk("rnd_drained", 64'(remaining()), 64'd0);
      chk("rnd_cnt", 64'(xfer_count_o), 64'(total));
    end
    chk("no_underflow", 64'(underflow), 64'd0);
    chk("rden_onehot", 64'(bad_oh), 64'd0);
    chk("hold_stable", 64'(bad_hold), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
